cpu16_seq: RTL and testbench

- Multi-cycle control sequencer for the cpu16 datapath. Replaces free-running fetch (PC+2 every clock) with a FETCH/DECODE/EXEC state machine.
- Owns PC and IR. Performs a req/ack handshake to instruction memory.
- Drives the one-hot ALU control (ICNT), register-file addresses and a register-file write enable.
- Stops on a HALT instruction, an illegal opcode or a memory timeout.

---
 rtl/cpu16_defs.sv | 30 +++
 rtl/cpu16_seq_dec.sv | 31 +++
 rtl/cpu16_seq.sv | 152 +++++++++++++++
 tb/tb_cpu16_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_defs.sv
// Shared encodings for the cpu16 control sequencer: ALU op bits, opcode/function
// fields, FSM state encoding and halt-cause codes.
package cpu16_defs;

  localparam int ISADD = 0;
  localparam int ISSUB = 1;
  localparam int ISAND = 2;
  localparam int ISOR  = 3;

  localparam logic [3:0] OP_ALU  = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] FN_ADD = 4'b1010;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b1100;
  localparam logic [3:0] FN_OR  = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/cpu16_seq_dec.sv
// Combinational instruction decoder: IR -> one-hot ALU op, HALT and illegal flags.
// Undefined encodings always yield icnt=0 so the ALU control never floats.
module cpu16_seq_dec
  import cpu16_defs::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  icnt,
  output logic        is_halt,
  output logic        is_illegal
);

  always_comb begin
    icnt       = 4'b0000;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (ir[15:12] == OP_HALT) begin
      is_halt = 1'b1;
    end else if (ir[15:12] == OP_ALU) begin
      case (ir[7:4])
        FN_ADD:  icnt[ISADD] = 1'b1;
        FN_SUB:  icnt[ISSUB] = 1'b1;
        FN_AND:  icnt[ISAND] = 1'b1;
        FN_OR:   icnt[ISOR]  = 1'b1;
        default: is_illegal  = 1'b1;
      endcase
    end else begin
      is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/cpu16_seq.sv
// FETCH/DECODE/EXEC control sequencer for the cpu16 datapath: owns PC and IR,
// handshakes with instruction memory, and halts on HALT, illegal opcode or fetch timeout.
module cpu16_seq
  import cpu16_defs::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        CK,
  input  logic        RST_N,
  input  logic        RUN,
  output logic        MEM_REQ,
  output logic [15:0] MEM_ADDR,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [15:0] IR,
  output logic [3:0]  ICNT,
  output logic [3:0]  DEST,
  output logic [3:0]  SRC,
  output logic        RF_WE,
  output logic        BUSY,
  output logic        HALTED,
  output logic [1:0]  ERR,
  output logic [15:0] INSN_CNT
);

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [7:0]  wait_cnt;
  logic [1:0]  err;
  logic [15:0] insn_cnt;
  logic        run_q;

  logic [3:0]  dec_icnt;
  logic        dec_halt;
  logic        dec_illegal;
  logic        timeout;
  logic        run_rise;

  cpu16_seq_dec u_dec (
    .ir         (ir),
    .icnt       (dec_icnt),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  assign timeout  = (wait_cnt == TMO_LAST);
  // Restart from HALT needs a fresh RUN edge, so a level held through halt entry is ignored.
  assign run_rise = RUN & ~run_q;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (RUN) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (MEM_ACK)      state_nxt = ST_DECODE;
        else if (timeout) state_nxt = ST_HALT;
      end
      ST_DECODE: state_nxt = (dec_halt || dec_illegal) ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_nxt = RUN ? ST_FETCH : ST_IDLE;
      ST_HALT:   if (run_rise) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    MEM_REQ = 1'b0;
    ICNT    = 4'b0000;
    RF_WE   = 1'b0;
    BUSY    = 1'b0;
    HALTED  = 1'b0;
    case (state)
      ST_FETCH: begin
        MEM_REQ = 1'b1;
        BUSY    = 1'b1;
      end
      ST_DECODE: begin
        ICNT = dec_icnt;
        BUSY = 1'b1;
      end
      ST_EXEC: begin
        ICNT  = dec_icnt;
        RF_WE = 1'b1;
        BUSY  = 1'b1;
      end
      ST_HALT: HALTED = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      pc       <= RESET_PC;
      ir       <= 16'h0000;
      wait_cnt <= 8'd0;
      err      <= ERR_NONE;
      insn_cnt <= 16'h0000;
      run_q    <= 1'b0;
    end else begin
      run_q <= RUN;
      case (state)
        ST_IDLE: begin
          wait_cnt <= 8'd0;
          if (RUN) pc <= RESET_PC;
        end
        ST_FETCH: begin
          if (MEM_ACK) begin
            ir       <= MEM_RDATA;
            pc       <= pc + 16'd2;
            wait_cnt <= 8'd0;
          end else if (timeout) begin
            err      <= ERR_TIMEOUT;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DECODE: begin
          if (dec_halt) begin
            err      <= ERR_NONE;
            insn_cnt <= insn_cnt + 16'd1;
          end else if (dec_illegal) begin
            err <= ERR_ILLEGAL;
          end
        end
        ST_EXEC: insn_cnt <= insn_cnt + 16'd1;
        ST_HALT: if (run_rise) err <= ERR_NONE;
        default: ;
      endcase
    end
  end

  assign MEM_ADDR = {pc[15:1], 1'b0};
  assign IR       = ir;
  assign DEST     = ir[11:8];
  assign SRC      = ir[3:0];
  assign ERR      = err;
  assign INSN_CNT = insn_cnt;

endmodule

// File: tb/tb_cpu16_seq.sv
// Bench for cpu16_seq: random programs and fetch latencies against an
// instruction-level model, plus directed timeout, illegal, reset and RUN-drop cases.
module tb_cpu16_seq;

  localparam logic [15:0] RPC    = 16'h0000;
  localparam int          ACK_TO = 15;

  logic        CK = 1'b0;
  logic        RST_N;
  logic        RUN;
  logic        MEM_REQ;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_RDATA;
  logic        MEM_ACK;
  logic [15:0] IR;
  logic [3:0]  ICNT;
  logic [3:0]  DEST;
  logic [3:0]  SRC;
  logic        RF_WE;
  logic        BUSY;
  logic        HALTED;
  logic [1:0]  ERR;
  logic [15:0] INSN_CNT;

  cpu16_seq #(.RESET_PC(RPC), .ACK_TIMEOUT(ACK_TO)) dut (
    .CK(CK), .RST_N(RST_N), .RUN(RUN),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .IR(IR), .ICNT(ICNT), .DEST(DEST), .SRC(SRC), .RF_WE(RF_WE),
    .BUSY(BUSY), .HALTED(HALTED), .ERR(ERR), .INSN_CNT(INSN_CNT)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [15:0] mem [0:63];
  int          lat [0:63];
  int          fidx = 0;
  int          wait_n = 0;
  bit          no_ack = 0;
  int          cyc = 0;
  int          req_cnt = 0;
  logic [3:0]  icnt_or = 4'b0;
  bit          prev_req = 0;
  logic [15:0] prev_addr = 16'h0;
  int          ack_cyc[$];
  logic [15:0] ack_addr[$];
  int          rf_cyc[$];
  logic [3:0]  rf_icnt[$];
  logic [3:0]  rf_dest[$];
  logic [3:0]  rf_src[$];

  initial forever begin
    @(posedge CK);
    cyc++;
  end

  // Memory responder and monitor: samples at negedge, then drives ack/data for the next edge.
  initial begin
    MEM_ACK   = 1'b0;
    MEM_RDATA = 16'h0;
    forever begin
      @(negedge CK);
      if (MEM_REQ && prev_req) check_eq("addr_stable", MEM_ADDR, prev_addr);
      if (RF_WE) begin
        rf_cyc.push_back(cyc);
        rf_icnt.push_back(ICNT);
        rf_dest.push_back(DEST);
        rf_src.push_back(SRC);
      end
      if (ICNT != 4'b0) check_eq("icnt_onehot", $countones(ICNT), 1);
      icnt_or  |= ICNT;
      if (MEM_REQ) req_cnt++;
      prev_req  = MEM_REQ;
      prev_addr = MEM_ADDR;
      if (MEM_REQ && !no_ack) begin
        if (wait_n >= lat[fidx % 64]) begin
          MEM_ACK   = 1'b1;
          MEM_RDATA = mem[MEM_ADDR[6:1]];
          ack_cyc.push_back(cyc);
          ack_addr.push_back(MEM_ADDR);
          fidx++;
          wait_n = 0;
        end else begin
          MEM_ACK   = 1'b0;
          MEM_RDATA = 16'($urandom);
          wait_n++;
        end
      end else if (MEM_REQ) begin
        MEM_ACK = 1'b0;
      end else begin
        // Spurious acks outside FETCH must be ignored.
        MEM_ACK   = 1'($urandom_range(0, 1));
        MEM_RDATA = 16'($urandom);
      end
    end
  end

  task automatic clear_mon();
    ack_cyc.delete(); ack_addr.delete();
    rf_cyc.delete(); rf_icnt.delete(); rf_dest.delete(); rf_src.delete();
    icnt_or = 4'b0;
    req_cnt = 0;
  endtask

  task automatic do_reset();
    RST_N  = 1'b0;
    RUN    = 1'b0;
    no_ack = 1'b0;
    fidx   = 0;
    wait_n = 0;
    repeat (2) @(negedge CK);
    #1 RST_N = 1'b1;
    @(negedge CK);
    #1 clear_mon();
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CK);
      #1;
      if (HALTED) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [3:0] alu_onehot(input logic [15:0] w);
    if (w[15:12] != 4'h0) return 4'b0000;
    case (w[7:4])
      4'hA:    return 4'b0001;
      4'h2:    return 4'b0010;
      4'hC:    return 4'b0100;
      4'hE:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // Runs mem[] from RESET_PC to halt and compares against an instruction-level model.
  task automatic run_prog();
    bit          ok;
    int          nf;
    int          ecnt;
    int          ereq;
    int          c0;
    int          n;
    logic [1:0]  eerr;
    logic [3:0]  eor;
    logic [15:0] w;
    logic [3:0]  eicnt[$];
    logic [3:0]  edest[$];
    logic [3:0]  esrc[$];
    do_reset();
    @(negedge CK);
    #1 RUN = 1'b1;
    c0 = cyc;
    wait_halt(2000, ok);
    check_eq("halt_reached", ok, 1);

    nf = 0; ecnt = 0; ereq = 0; eerr = 2'b00; eor = 4'b0;
    for (int k = 0; k < 64; k++) begin
      w = mem[k];
      nf++;
      ereq += 1 + lat[k];
      if (w[15:12] == 4'hF) begin
        eerr = 2'b00;
        ecnt++;
        break;
      end
      if (alu_onehot(w) == 4'b0) begin
        eerr = 2'b01;
        break;
      end
      eicnt.push_back(alu_onehot(w));
      edest.push_back(w[11:8]);
      esrc.push_back(w[3:0]);
      eor |= alu_onehot(w);
      ecnt++;
    end

    check_eq("n_fetch", ack_cyc.size(), nf);
    check_eq("req_cycles", req_cnt, ereq);
    n = (ack_cyc.size() < nf) ? ack_cyc.size() : nf;
    for (int k = 0; k < n; k++) begin
      check_eq("fetch_addr", ack_addr[k], 16'(RPC + 16'(2 * k)));
      if (k == 0) check_eq("first_ack_cyc", ack_cyc[0] - c0, 1 + lat[0]);
      else        check_eq("fetch_spacing", ack_cyc[k] - ack_cyc[k-1], 3 + lat[k]);
    end
    check_eq("n_rf_we", rf_cyc.size(), eicnt.size());
    n = (rf_cyc.size() < eicnt.size()) ? rf_cyc.size() : eicnt.size();
    for (int k = 0; k < n; k++) begin
      check_eq("rf_icnt", rf_icnt[k], eicnt[k]);
      check_eq("rf_dest", rf_dest[k], edest[k]);
      check_eq("rf_src", rf_src[k], esrc[k]);
      if (k < ack_cyc.size()) check_eq("rf_we_latency", rf_cyc[k] - ack_cyc[k], 2);
    end
    check_eq("icnt_seen", icnt_or, eor);
    check_eq("err", ERR, eerr);
    check_eq("insn_cnt", INSN_CNT, ecnt);
    if (nf > 0) check_eq("ir_last", IR, mem[nf-1]);

    repeat (3) @(negedge CK);
    #1 check_eq("halt_hold_run_high", HALTED, 1);
    check_eq("halt_rf_we", RF_WE, 0);
    RUN = 1'b0;
    @(negedge CK);
    #1 RUN = 1'b1;
    @(negedge CK);
    #1 check_eq("restart_idle_halted", HALTED, 0);
    check_eq("restart_idle_busy", BUSY, 0);
    check_eq("restart_err_clear", ERR, 2'b00);
    @(negedge CK);
    #1 check_eq("restart_fetch_req", MEM_REQ, 1);
    check_eq("restart_fetch_addr", MEM_ADDR, RPC);
  endtask

  task automatic gen_prog();
    int n;
    int kind;
    n = $urandom_range(1, 10);
    for (int k = 0; k < 64; k++) begin
      mem[k] = 16'($urandom);
      lat[k] = $urandom_range(0, 3);
    end
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0:       mem[k] = {4'h0, 4'($urandom), 4'hA, 4'($urandom)};
        1:       mem[k] = {4'h0, 4'($urandom), 4'h2, 4'($urandom)};
        2:       mem[k] = {4'h0, 4'($urandom), 4'hC, 4'($urandom)};
        default: mem[k] = {4'h0, 4'($urandom), 4'hE, 4'($urandom)};
      endcase
    end
    kind = $urandom_range(0, 2);
    if (kind == 0)      mem[n] = {4'hF, 12'($urandom)};
    else if (kind == 1) mem[n] = {4'h0, 4'($urandom), 4'h3, 4'($urandom)};
    else                mem[n] = {4'($urandom_range(1, 14)), 12'($urandom)};
  endtask

  task automatic load_plan();
    for (int k = 0; k < 64; k++) begin
      mem[k] = 16'hF000;
      lat[k] = 0;
    end
    mem[0] = 16'h01A3; mem[1] = 16'h0520; mem[2] = 16'h0CCA;
    mem[3] = 16'h08EB; mem[4] = 16'hF000;
  endtask

  initial begin
    bit ok;
    RST_N = 1'b0;
    RUN   = 1'b0;
    for (int k = 0; k < 64; k++) begin
      mem[k] = 16'h0;
      lat[k] = 0;
    end

    do_reset();
    check_eq("rst_mem_req", MEM_REQ, 0);
    check_eq("rst_mem_addr", MEM_ADDR, RPC);
    check_eq("rst_ir", IR, 0);
    check_eq("rst_icnt", ICNT, 0);
    check_eq("rst_dest_src", {DEST, SRC}, 0);
    check_eq("rst_rf_we", RF_WE, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_halted", HALTED, 0);
    check_eq("rst_err", ERR, 0);
    check_eq("rst_insn_cnt", INSN_CNT, 0);

    load_plan();
    run_prog();
    load_plan();
    lat[1] = 3;
    run_prog();
    for (int k = 0; k < 64; k++) lat[k] = 0;
    mem[0] = 16'h0030;
    run_prog();

    do_reset();
    no_ack = 1'b1;
    @(negedge CK);
    #1 RUN = 1'b1;
    wait_halt(100, ok);
    check_eq("tmo_halt_reached", ok, 1);
    check_eq("tmo_fetch_cycles", req_cnt, ACK_TO);
    check_eq("tmo_err", ERR, 2'b10);
    check_eq("tmo_insn_cnt", INSN_CNT, 0);
    check_eq("tmo_no_rf_we", rf_cyc.size(), 0);
    no_ack = 1'b0;

    load_plan();
    do_reset();
    @(negedge CK);
    #1 RUN = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CK);
      #1 ok = RF_WE;
    end
    check_eq("exec_reached", ok, 1);
    #1 RST_N = 1'b0;
    #1 check_eq("arst_rf_we", RF_WE, 0);
    check_eq("arst_busy", BUSY, 0);
    check_eq("arst_icnt", ICNT, 0);
    check_eq("arst_addr", MEM_ADDR, RPC);
    RUN = 1'b0;
    @(negedge CK);
    #1 RST_N = 1'b1;
    @(negedge CK);
    #1 check_eq("arst_idle_busy", BUSY, 0);
    check_eq("arst_idle_halted", HALTED, 0);
    check_eq("arst_pc", MEM_ADDR, RPC);
    check_eq("arst_insn_cnt", INSN_CNT, 0);

    load_plan();
    lat[0] = 2;
    do_reset();
    @(negedge CK);
    #1 RUN = 1'b1;
    @(negedge CK);
    #1 RUN = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CK);
      #1 ok = !BUSY;
    end
    check_eq("rundrop_stopped", ok, 1);
    repeat (3) @(negedge CK);
    #1 check_eq("rundrop_busy", BUSY, 0);
    check_eq("rundrop_halted", HALTED, 0);
    check_eq("rundrop_rf_we_cnt", rf_cyc.size(), 1);
    check_eq("rundrop_insn_cnt", INSN_CNT, 1);

    for (int r = 0; r < 25; r++) begin
      gen_prog();
      run_prog();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
